rdata_chan_mngr_p: RTL

- Parametrised AXI read-data channel manager; successor to the fixed 4x32 read data manager.
- Sits between the AXI R channel and the cache/line-fill side.
- Queues up to OUTST expected read IDs issued by the address side.
- Accepts R beats only for the ID at the head of the queue and assembles a BURST x DW line.
- Presents the line downstream with a valid/ready handshake; no fixed full-flag stall.

---
 rtl/rdata_chan_mngr_p.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/rdata_chan_mngr_p.sv
// AXI R-channel manager: queues expected read IDs, assembles BURST x DW lines for the head ID.
// Optional RRESP error tracking is compiled in with `define RDAT_RRESP_EN.
module rdata_chan_mngr_p #(
    parameter int DW    = 32,
    parameter int BURST = 4,
    parameter int IDW   = 4,
    parameter int OUTST = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rvalid,
    output logic                rready,
    input  logic [IDW-1:0]      rid,
    input  logic [DW-1:0]       rdata,
    input  logic                rlast,
    input  logic                next_rrq,
    input  logic [IDW-1:0]      next_rid,
    output logic                rq_full,
    output logic [DW*BURST-1:0] rdat_m_data,
    output logic [IDW-1:0]      rdat_m_id,
    output logic                rdat_m_valid,
    input  logic                rdat_m_ready,
    output logic                rdat_m_ovf,
`ifdef RDAT_RRESP_EN
    input  logic [1:0]          rresp,
    output logic                rdat_m_err,
`endif
    output logic                finish_mrd
);

    localparam int CW  = $clog2(BURST);
    localparam int PW  = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int QCW = $clog2(OUTST + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        HOLD
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [IDW-1:0]  q_mem [OUTST];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [QCW-1:0]  q_count_reg;
    logic [DW-1:0]   line_reg [BURST];
    logic [IDW-1:0]  id_reg;
    logic            ovf_reg;
    logic [IDW-1:0]  head_id;
    logic            beat_acc;
    logic            push;
    logic            pop;
    logic            hand_off;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Expected-ID queue
    // ------------------------------------------------------------------
    assign rq_full  = (q_count_reg == QCW'(OUTST));
    assign push     = next_rrq & ~rq_full;
    assign head_id  = q_mem[rd_ptr_reg];
    assign beat_acc = rvalid & rready;
    assign pop      = beat_acc & rlast;
    assign hand_off = (state_reg == HOLD) & rdat_m_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_reg] <= next_rid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            q_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   q_count_reg <= q_count_reg + QCW'(1);
                2'b01:   q_count_reg <= q_count_reg - QCW'(1);
                default: q_count_reg <= q_count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rready     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (q_count_reg != '0) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                rready = (rid == head_id);
                if (beat_acc) begin
                    if (rlast) begin
                        state_next = HOLD;
                    end else if (cnt_reg == CW'(BURST - 1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                rready = (rid == head_id);
                if (pop) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (rdat_m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat counter only advances on RECV beats; the DRAIN entry wrap is harmless
    // because the counter is cleared when rlast is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (pop) begin
            cnt_reg <= '0;
        end else if (beat_acc && state_reg == RECV) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: one register slot per beat
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BURST; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_reg[gi] <= '0;
                end else if (beat_acc && state_reg == RECV) begin
                    if (cnt_reg == CW'(gi)) begin
                        line_reg[gi] <= rdata;
                    end else if (rlast && (CW'(gi) > cnt_reg)) begin
                        line_reg[gi] <= '0;
                    end
                end
            end
            assign rdat_m_data[gi*DW +: DW] = line_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg  <= '0;
            ovf_reg <= 1'b0;
        end else begin
            if (pop) begin
                id_reg <= head_id;
            end
            if (pop && state_reg == DRAIN) begin
                ovf_reg <= 1'b1;
            end else if (hand_off) begin
                ovf_reg <= 1'b0;
            end
        end
    end

`ifdef RDAT_RRESP_EN
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (hand_off) begin
            err_reg <= 1'b0;
        end else if (beat_acc) begin
            err_reg <= err_reg | rresp[1];
        end
    end

    assign rdat_m_err = err_reg;
`endif

    assign rdat_m_id    = id_reg;
    assign rdat_m_ovf   = ovf_reg;
    assign rdat_m_valid = (state_reg == HOLD);
    assign finish_mrd   = rdat_m_valid & rdat_m_ready;

endmodule
